// File: rtl/lsu_mem_master.sv
`timescale 1ns/1ps
// Purpose: CPU-side load/store initiator; one aligned-checked access at a time toward data memory/MMIO.
// Latency: store/error response 2 cycles after the accept edge, load response 2+RD_LAT cycles.
// Backpressure: req_ready only in IDLE; requester holds req_valid, busy stalls the pipeline until RESP ends.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake; req_we/size/sign/addr/wdata request fields
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse; rsp_rdata holds until the next load/error
//   busy                         high from acceptance through the RESP cycle
//   mem_addr/mem_re/mem_we       word-aligned memory access, single-cycle strobes
//   mem_wstrb/mem_wdata          byte-lane enables and lane-replicated store data
//   mem_rdata                    read word, valid RD_LAT cycles after mem_re
module lsu_mem_master #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nxt;

    logic        we_q, sign_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [2:0]  cnt_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;

    logic        accept, req_err, load_done;
    logic [3:0]  store_strb;
    logic [31:0] shifted, lane_data, wdata_rep;

    assign accept = req_valid && (state == S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = (req_addr[1:0] != 2'b00);
            2'd3:    req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        wdata_rep = req_wdata;
        case (req_size)
            2'd0:    wdata_rep = {4{req_wdata[7:0]}};
            2'd1:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    always_comb begin
        store_strb = 4'b1111;
        case (size_q)
            2'd0:    store_strb = 4'b0001 << lane_q;
            2'd1:    store_strb = lane_q[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    end

    // Half accesses are 2-byte aligned, so shifting by the byte lane also selects the half.
    assign shifted = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        lane_data = mem_rdata;
        case (size_q)
            2'd0:    lane_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'd1:    lane_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: lane_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        load_done = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = S_ACC;
            end
            S_ACC: begin
                if (err_q) begin
                    state_nxt = S_RESP;
                end else if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wstrb = store_strb;
                    state_nxt = S_RESP;
                end else begin
                    mem_re    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter is about to hit zero: mem_rdata is valid this cycle.
                if (cnt_q == 3'd1) begin
                    load_done = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            cnt_q       <= 3'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q        <= req_we;
                sign_q      <= req_sign;
                err_q       <= req_err;
                size_q      <= req_size;
                lane_q      <= req_addr[1:0];
                mem_addr_q  <= {req_addr[31:2], 2'b00};
                mem_wdata_q <= wdata_rep;
            end
            if (state == S_ACC) begin
                cnt_q <= 3'(RD_LAT);
                if (err_q) rdata_q <= 32'd0;
            end
            if (state == S_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (load_done) begin
                rdata_q <= lane_data;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
`timescale 1ns/1ps
// Bench for lsu_mem_master: two instances (RD_LAT 1 and 3) sharing request fields,
// each with its own latency-accurate memory model; directed cases plus random
// traffic checked against a byte-arithmetic reference model.
module tb_lsu_mem_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic        req_sign  = 1'b0;
    logic [1:0]  req_size  = 2'd0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_word  = 32'd0;
    int          sel       = 0;

    logic [1:0]        vld_d, ready_d, rsp_valid_d, rsp_err_d, busy_d, mem_re_d, mem_we_d;
    logic [1:0][31:0]  rsp_rdata_d, mem_addr_d, wdata_d, rdata_d;
    logic [1:0][3:0]   wstrb_d;

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_rd [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic mact = 1'b0;
        int   mcnt = 0;

        assign vld_d[k] = req_valid && (sel == k);

        lsu_mem_master #(.RD_LAT(LAT)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (vld_d[k]),
            .req_ready (ready_d[k]),
            .req_we    (req_we),
            .req_size  (req_size),
            .req_sign  (req_sign),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid_d[k]),
            .rsp_rdata (rsp_rdata_d[k]),
            .rsp_err   (rsp_err_d[k]),
            .busy      (busy_d[k]),
            .mem_addr  (mem_addr_d[k]),
            .mem_re    (mem_re_d[k]),
            .mem_we    (mem_we_d[k]),
            .mem_wstrb (wstrb_d[k]),
            .mem_wdata (wdata_d[k]),
            .mem_rdata (rdata_d[k])
        );

        // Memory: word valid only in the cycle LAT cycles after mem_re, garbage otherwise.
        always @(posedge clk) begin
            if (mem_re_d[k]) begin
                mact <= 1'b1;
                mcnt <= LAT - 1;
            end else if (mact) begin
                if (mcnt == 0) mact <= 1'b0;
                else mcnt <= mcnt - 1;
            end
        end
        assign rdata_d[k] = (mact && mcnt == 0) ? mem_word : 32'hDEAD_BEEF;
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Reference: access of 2**size bytes at byte offset addr%4.
    function automatic void ref_model(input logic we, input logic [1:0] size, input logic sign,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] word, input logic [31:0] prev,
                                      output logic err, output logic [31:0] rdata,
                                      output logic [3:0] strb, output logic [31:0] wrep);
        int nb, off;
        logic [31:0] mask, v;
        nb   = 1 << size;
        off  = int'(addr % 4);
        err  = (size == 2'd3) || ((addr % nb) != 0);
        rdata = prev;
        strb = 4'b0000;
        wrep = 32'd0;
        if (err) begin
            rdata = 32'd0;
            return;
        end
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (we) begin
            strb = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4 / nb; i++) wrep = wrep | ((wdata & mask) << (8 * nb * i));
        end else begin
            v = (word >> (8 * off)) & mask;
            if (sign && v[8 * nb - 1]) v = v | ~mask;
            rdata = v;
        end
    endfunction

    // Driver: presents one request at a negedge and records what the DUT does until its response.
    task automatic run_txn(input int k, input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int rsp_cyc, output logic [31:0] rdata, output logic err,
                           output int re_n, output int we_n, output logic [3:0] strb,
                           output logic [31:0] maddr, output logic [31:0] wd, output int busy_low);
        int w;
        sel = k; req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_cyc = -1; rdata = 32'd0; err = 1'b0; re_n = 0; we_n = 0; strb = 4'd0;
        maddr = 32'd0; wd = 32'd0; busy_low = 0;
        w = 0;
        while (!ready_d[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_re_d[k]) re_n++;
            if (mem_we_d[k]) begin
                we_n++;
                strb = wstrb_d[k];
                wd   = wdata_d[k];
            end
            if (!busy_d[k]) busy_low++;
            if (rsp_valid_d[k]) begin
                rsp_cyc = c;
                rdata   = rsp_rdata_d[k];
                err     = rsp_err_d[k];
                maddr   = mem_addr_d[k];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    int          t_cyc, t_re, t_we, t_bl;
    logic [31:0] t_rd, t_ma, t_wd;
    logic        t_err;
    logic [3:0]  t_strb;

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ready_d[k], rsp_valid_d[k], rsp_err_d[k], busy_d[k], mem_re_d[k], mem_we_d[k], wstrb_d[k],
                 mem_addr_d[k], wdata_d[k], rsp_rdata_d[k]} !== {6'b100000, 4'd0, 96'd0}) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b vld=%b err=%b busy=%b re=%b we=%b strb=%b addr=%h wd=%h rd=%h, required ready=1 rest 0",
                         k, ready_d[k], rsp_valid_d[k], rsp_err_d[k], busy_d[k], mem_re_d[k], mem_we_d[k],
                         wstrb_d[k], mem_addr_d[k], wdata_d[k], rsp_rdata_d[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        run_txn(0, 1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'hAABB_CCDD, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
        checks++; if (t_we !== 1 || t_re !== 0) begin errors++; $display("FAIL sb_strobes: we_cycles=%0d re_cycles=%0d, required 1 and 0", t_we, t_re); end
        checks++; if (t_strb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b, required 1000", t_strb); end
        checks++; if (t_wd !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata: got %h, required dddddddd", t_wd); end
        checks++; if (t_ma !== 32'h10) begin errors++; $display("FAIL sb_addr: got %h, required 00000010", t_ma); end
        checks++; if (t_cyc !== 2 || t_err !== 1'b0) begin errors++; $display("FAIL sb_rsp: cycle=%0d err=%b, required cycle 2 err 0", t_cyc, t_err); end
        checks++; if (t_bl !== 0) begin errors++; $display("FAIL sb_busy: busy low %0d cycles, required 0", t_bl); end
    endtask

    task automatic test_load_half();
        mem_word = 32'h8001_1234;
        run_txn(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
        checks++; if (t_rd !== 32'hFFFF_8001 || t_cyc !== 3) begin errors++; $display("FAIL lh_signed: data=%h cycle=%0d, required ffff8001 cycle 3", t_rd, t_cyc); end
        checks++; if (t_re !== 1 || t_we !== 0 || t_err !== 1'b0) begin errors++; $display("FAIL lh_strobes: re=%0d we=%0d err=%b, required 1 0 0", t_re, t_we, t_err); end
        run_txn(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
        checks++; if (t_rd !== 32'h0000_8001 || t_cyc !== 3) begin errors++; $display("FAIL lh_unsigned: data=%h cycle=%0d, required 00008001 cycle 3", t_rd, t_cyc); end
    endtask

    task automatic test_load_byte();
        mem_word = 32'h1122_33F0;
        run_txn(0, 1'b0, 2'd0, 1'b0, 32'h41, 32'd0, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
        checks++; if (t_rd !== 32'h0000_0033) begin errors++; $display("FAIL lb_unsigned: got %h, required 00000033", t_rd); end
        checks++; if (t_ma !== 32'h40) begin errors++; $display("FAIL lb_addr: got %h, required 00000040", t_ma); end
        run_txn(0, 1'b0, 2'd0, 1'b1, 32'h40, 32'd0, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
        checks++; if (t_rd !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_signed: got %h, required fffffff0", t_rd); end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
        logic        wr [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ad [3] = '{32'h02, 32'h05, 32'h00};
        for (int i = 0; i < 3; i++) begin
            run_txn(0, wr[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
            checks++;
            if (t_re !== 0 || t_we !== 0 || t_err !== 1'b1 || t_cyc !== 2 || t_rd !== 32'd0) begin
                errors++;
                $display("FAIL misaligned_%0d: re=%0d we=%0d err=%b cycle=%0d data=%h, required 0 0 1 cycle 2 data 0",
                         i, t_re, t_we, t_err, t_cyc, t_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, acc2, bl;
        logic [31:0] d1;
        r1 = -1; r2 = -1; acc2 = -1; bl = 0; d1 = 32'd0;
        mem_word = 32'hCAFE_F00D;
        sel = 1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'h100; req_wdata = 32'd0;
        req_valid = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h1234_5678;
            end
            if (acc2 > 0 && c == acc2 + 1) req_valid = 1'b0;
            if (rsp_valid_d[1]) begin
                if (r1 < 0) begin r1 = c; d1 = rsp_rdata_d[1]; end
                else if (r2 < 0) r2 = c;
            end
            if (ready_d[1] && acc2 < 0) acc2 = c;
            if (!busy_d[1] && ((r1 < 0 || c <= r1) || (acc2 > 0 && c > acc2 && (r2 < 0 || c <= r2)))) bl++;
        end
        req_valid = 1'b0;
        checks++; if (r1 !== 5 || d1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_first: cycle=%0d data=%h, required cycle 5 data cafef00d", r1, d1); end
        checks++; if (acc2 !== 6) begin errors++; $display("FAIL b2b_accept: ready in cycle %0d, required 6", acc2); end
        checks++; if (r2 !== 8) begin errors++; $display("FAIL b2b_second: cycle=%0d, required 8", r2); end
        checks++; if (bl !== 0) begin errors++; $display("FAIL b2b_busy: busy low %0d cycles within accesses, required 0", bl); end
    endtask

    task automatic test_random();
        int k, e_cyc;
        logic we, sign, e_err;
        logic [1:0] size;
        logic [31:0] addr, wd, e_rd, e_wrep;
        logic [3:0] e_strb;
        for (int kk = 0; kk < 2; kk++) begin
            run_txn(kk, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
            checks++; if (t_err !== 1'b1 || t_rd !== 32'd0) begin errors++; $display("FAIL rnd_seed_%0d: err=%b data=%h, required 1 and 0", kk, t_err, t_rd); end
            prev_rd[kk] = 32'd0;
        end
        for (int n = 0; n < 60; n++) begin
            k    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sign = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd   = $urandom;
            mem_word = $urandom;
            if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            ref_model(we, size, sign, addr, wd, mem_word, prev_rd[k], e_err, e_rd, e_strb, e_wrep);
            e_cyc = (e_err || we) ? 2 : 2 + lat_of(k);
            run_txn(k, we, size, sign, addr, wd, t_cyc, t_rd, t_err, t_re, t_we, t_strb, t_ma, t_wd, t_bl);
            checks++;
            if (t_cyc !== e_cyc || t_err !== e_err || t_rd !== e_rd || t_ma !== {addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL rnd_rsp_%0d: dut%0d we=%b size=%0d addr=%h cycle=%0d err=%b data=%h maddr=%h, required cycle=%0d err=%b data=%h maddr=%h",
                         n, k, we, size, addr, t_cyc, t_err, t_rd, t_ma, e_cyc, e_err, e_rd, {addr[31:2], 2'b00});
            end
            checks++;
            if (t_re !== ((!we && !e_err) ? 1 : 0) || t_we !== ((we && !e_err) ? 1 : 0) ||
                (we && !e_err && (t_strb !== e_strb || t_wd !== e_wrep))) begin
                errors++;
                $display("FAIL rnd_mem_%0d: re=%0d we=%0d strb=%b wdata=%h, required strb=%b wdata=%h",
                         n, t_re, t_we, t_strb, t_wd, e_strb, e_wrep);
            end
            prev_rd[k] = e_rd;
        end
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        pulses = 0;
        mem_word = 32'h7777_7777;
        sel = 1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'h300; req_wdata = 32'd0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy_d[1] !== 1'b1) begin errors++; $display("FAIL rst_pre: busy=%b before reset, required 1", busy_d[1]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_d[1], rsp_valid_d[1], rsp_err_d[1], busy_d[1], mem_re_d[1], mem_we_d[1], wstrb_d[1],
             mem_addr_d[1], wdata_d[1], rsp_rdata_d[1]} !== {6'b100000, 4'd0, 96'd0}) begin
            errors++;
            $display("FAIL rst_mid_wait: ready=%b busy=%b addr=%h rd=%h, required ready=1 rest 0",
                     ready_d[1], busy_d[1], mem_addr_d[1], rsp_rdata_d[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid_d[1]) pulses++;
        end
        checks++; if (pulses !== 0 || ready_d[1] !== 1'b1) begin errors++; $display("FAIL rst_no_rsp: pulses=%0d ready=%b, required 0 and 1", pulses, ready_d[1]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_byte();
        test_misaligned();
        test_back_to_back();
        @(negedge clk);
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
